// File: rtl/pool_pkg.sv
// rtl/pool_pkg.sv - shared types and helpers for the pooling engine
package pool_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_WR_REQ,
        ST_DONE
    } pool_state_t;

    typedef enum logic {
        POOL_MAX = 1'b0,
        POOL_AVG = 1'b1
    } pool_mode_t;

    // Job fields latched on an accepted start; shift is 0 in max mode.
    typedef struct packed {
        pool_mode_t mode;
        logic [2:0] k;
        logic [2:0] s;
        logic [3:0] shift;
    } pool_cfg_t;

    // log2(K*K) for the window edges that average mode accepts.
    function automatic logic [3:0] log2_k2(input logic [2:0] k);
        case (k)
            3'd2:    log2_k2 = 4'd2;
            3'd4:    log2_k2 = 4'd4;
            default: log2_k2 = 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/pool_reduce.sv
// rtl/pool_reduce.sv - window accumulator: running signed max or sum
module pool_reduce
    import pool_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int MAX_K  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              en,
    input  pool_mode_t        mode,
    input  logic [3:0]        shift,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] result
);

    // Wide enough to hold the sum of MAX_K*MAX_K elements without overflow.
    localparam int SUM_W = DATA_W + 2 * $clog2(MAX_K);

    logic signed [SUM_W-1:0] acc;
    logic signed [SUM_W-1:0] data_ext;

    assign data_ext = {{(SUM_W - DATA_W){data[DATA_W-1]}}, data};

    // First element of a window loads the accumulator, later ones fold in.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (en) begin
            if (clear) begin
                acc <= data_ext;
            end else if (mode == POOL_AVG) begin
                acc <= acc + data_ext;
            end else if (data_ext > acc) begin
                acc <= data_ext;
            end
        end
    end

    // Arithmetic shift floors toward minus infinity; the mean always fits DATA_W.
    assign result = DATA_W'(acc >>> shift);

endmodule

// File: rtl/pool_engine.sv
// rtl/pool_engine.sv - multi-cycle 2-D max/average pooling engine
module pool_engine
    import pool_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 64,
    parameter int DIM_W  = 16,
    parameter int MAX_K  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] cfg_src,
    input  logic [ADDR_W-1:0] cfg_dst,
    input  logic [DIM_W-1:0]  cfg_h,
    input  logic [DIM_W-1:0]  cfg_w,
    input  logic [2:0]        cfg_k,
    input  logic [2:0]        cfg_s,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_gnt,
    input  logic              rd_valid,
    input  logic [DATA_W-1:0] rd_data,
    output logic              wr_req,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic              wr_ack,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int         LW     = 2 * DIM_W;
    localparam logic [2:0] MAX_K3 = 3'(MAX_K);

    pool_state_t       state;
    pool_cfg_t         cfg;
    logic [ADDR_W-1:0] src_q, dst_q;
    logic [DIM_W-1:0]  w_q, oh_q, ow_q, oy, ox, noy, nox, oh_c, ow_c;
    logic [2:0]        ky, kx, nky, nkx, s_div;
    logic              reject, win_last, out_last;

    // Start-time checks and output-map size from the raw configuration inputs.
    always_comb begin
        reject = (cfg_k == 3'd0) || (cfg_k > MAX_K3) || (cfg_s == 3'd0)
              || (DIM_W'(cfg_k) > cfg_h) || (DIM_W'(cfg_k) > cfg_w)
              || ((mode == POOL_AVG) && !(cfg_k == 3'd1 || cfg_k == 3'd2 || cfg_k == 3'd4));
        s_div  = (cfg_s == 3'd0) ? 3'd1 : cfg_s;
        oh_c   = (cfg_h - DIM_W'(cfg_k)) / DIM_W'(s_div) + DIM_W'(1);
        ow_c   = (cfg_w - DIM_W'(cfg_k)) / DIM_W'(s_div) + DIM_W'(1);
    end

    // Next position in row-major window order and row-major output order.
    always_comb begin
        win_last = (kx == cfg.k - 3'd1) && (ky == cfg.k - 3'd1);
        nkx      = (kx == cfg.k - 3'd1) ? 3'd0 : kx + 3'd1;
        nky      = (kx == cfg.k - 3'd1) ? ky + 3'd1 : ky;
        out_last = (ox == ow_q - DIM_W'(1)) && (oy == oh_q - DIM_W'(1));
        nox      = (ox == ow_q - DIM_W'(1)) ? '0 : ox + DIM_W'(1);
        noy      = (ox == ow_q - DIM_W'(1)) ? oy + DIM_W'(1) : oy;
    end

    function automatic logic [ADDR_W-1:0] elem_addr(input logic [DIM_W-1:0] oy_i,
                                                    input logic [DIM_W-1:0] ox_i,
                                                    input logic [2:0]       ky_i,
                                                    input logic [2:0]       kx_i);
        logic [LW-1:0] row, col;
        row = LW'(oy_i) * LW'(cfg.s) + LW'(ky_i);
        col = LW'(ox_i) * LW'(cfg.s) + LW'(kx_i);
        return src_q + (ADDR_W'(row * LW'(w_q) + col) << 1);
    endfunction

    pool_reduce #(
        .DATA_W (DATA_W),
        .MAX_K  (MAX_K)
    ) u_reduce (
        .clk    (clk),
        .rst    (rst),
        .clear  ((kx == 3'd0) && (ky == 3'd0)),
        .en     ((state == ST_RD_WAIT) && rd_valid),
        .mode   (cfg.mode),
        .shift  (cfg.shift),
        .data   (rd_data),
        .result (wr_data)
    );

    // Job sequencer: one read in flight, one write per finished window.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cfg     <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            w_q     <= '0;
            oh_q    <= '0;
            ow_q    <= '0;
            oy      <= '0;
            ox      <= '0;
            ky      <= '0;
            kx      <= '0;
            rd_req  <= 1'b0;
            rd_addr <= '0;
            wr_req  <= 1'b0;
            wr_addr <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (reject) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else begin
                            cfg     <= '{mode:  pool_mode_t'(mode), k: cfg_k, s: cfg_s,
                                         shift: (mode == POOL_AVG) ? log2_k2(cfg_k) : 4'd0};
                            src_q   <= cfg_src;
                            dst_q   <= cfg_dst;
                            w_q     <= cfg_w;
                            oh_q    <= oh_c;
                            ow_q    <= ow_c;
                            oy      <= '0;
                            ox      <= '0;
                            ky      <= '0;
                            kx      <= '0;
                            rd_addr <= cfg_src;
                            rd_req  <= 1'b1;
                            state   <= ST_RD_REQ;
                        end
                    end
                end
                ST_RD_REQ: begin
                    if (rd_gnt) begin
                        rd_req <= 1'b0;
                        state  <= ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    if (rd_valid) begin
                        if (win_last) begin
                            wr_addr <= dst_q + (ADDR_W'(LW'(oy) * LW'(ow_q) + LW'(ox)) << 1);
                            wr_req  <= 1'b1;
                            state   <= ST_WR_REQ;
                        end else begin
                            kx      <= nkx;
                            ky      <= nky;
                            rd_addr <= elem_addr(oy, ox, nky, nkx);
                            rd_req  <= 1'b1;
                            state   <= ST_RD_REQ;
                        end
                    end
                end
                ST_WR_REQ: begin
                    if (wr_ack) begin
                        wr_req <= 1'b0;
                        kx     <= '0;
                        ky     <= '0;
                        if (out_last) begin
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            ox      <= nox;
                            oy      <= noy;
                            rd_addr <= elem_addr(noy, nox, 3'd0, 3'd0);
                            rd_req  <= 1'b1;
                            state   <= ST_RD_REQ;
                        end
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pool_engine.sv
// tb/tb_pool_engine.sv - scoreboard bench for pool_engine with randomized memory latency
module tb_pool_engine;

    localparam int          DATA_W = 16;
    localparam int          ADDR_W = 64;
    localparam int          DIM_W  = 16;
    localparam int          MAX_K  = 4;
    localparam logic [63:0] SRC    = 64'h1000;
    localparam logic [63:0] DST    = 64'h8000;

    logic              clk, rst, start, mode;
    logic [ADDR_W-1:0] cfg_src, cfg_dst, rd_addr, wr_addr;
    logic [DIM_W-1:0]  cfg_h, cfg_w;
    logic [2:0]        cfg_k, cfg_s;
    logic              rd_req, rd_gnt, rd_valid, wr_req, wr_ack, busy, done, err;
    logic [DATA_W-1:0] rd_data, wr_data;

    pool_engine #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DIM_W(DIM_W), .MAX_K(MAX_K)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .cfg_src(cfg_src), .cfg_dst(cfg_dst), .cfg_h(cfg_h), .cfg_w(cfg_w),
        .cfg_k(cfg_k), .cfg_s(cfg_s),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .busy(busy), .done(done), .err(err)
    );

    typedef struct {
        logic [63:0] addr;
        logic [15:0] data;
    } wr_t;

    wr_t                exp_q[$];
    logic signed [15:0] mem [0:255];
    int  checks = 0, errors = 0;
    int  cyc = 0, reads = 0, writes = 0, done_count = 0, done_cyc = 0, rdreq_cycles = 0;
    logic done_err = 1'b0;
    bit  rand_mode = 1'b0;
    int  gnt_wait = 0, val_wait = 0, ack_wait = 0;
    bit  wait_data = 1'b0;
    logic [63:0] pend_addr = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] mem_rd(input logic [63:0] a);
        logic [63:0] idx;
        idx = (a - SRC) >> 1;
        if (idx < 64'd256) return mem[idx[7:0]];
        return 16'hdead;
    endfunction

    function automatic bit is_reject(input int m, input int h, input int w, input int k, input int s);
        return (k == 0) || (k > MAX_K) || (s == 0) || (k > h) || (k > w)
            || ((m == 1) && !(k == 1 || k == 2 || k == 4));
    endfunction

    // Reference model: pool the map in memory with plain integer arithmetic.
    task automatic expect_job(input int m, input int h, input int w, input int k, input int s,
                              output int nrd, output int nout);
        int oh, ow, kk, v, acc, q;
        wr_t e;
        oh = (h - k) / s + 1;
        ow = (w - k) / s + 1;
        kk = k * k;
        acc = 0;
        for (int oy = 0; oy < oh; oy++) begin
            for (int ox = 0; ox < ow; ox++) begin
                for (int ky = 0; ky < k; ky++) begin
                    for (int kx = 0; kx < k; kx++) begin
                        v = mem[(oy * s + ky) * w + ox * s + kx];
                        if (ky == 0 && kx == 0) acc = v;
                        else if (m == 0) acc = (v > acc) ? v : acc;
                        else acc += v;
                    end
                end
                if (m == 1) begin
                    q = acc / kk;
                    if ((acc % kk) != 0 && acc < 0) q--;
                    acc = q;
                end
                e.addr = DST + 64'(2 * (oy * ow + ox));
                e.data = acc[15:0];
                exp_q.push_back(e);
            end
        end
        nrd  = oh * ow * kk;
        nout = oh * ow;
    endtask

    // Read port: grant after a random wait, return data a random time later.
    initial begin
        rd_gnt = 1'b0; rd_valid = 1'b0; rd_data = '0;
        forever begin
            @(negedge clk); #1;
            rd_gnt = 1'b0; rd_valid = 1'b0;
            if (rst) begin
                wait_data = 1'b0; gnt_wait = 0;
            end else if (wait_data) begin
                if (val_wait == 0) begin
                    rd_valid = 1'b1; rd_data = mem_rd(pend_addr); wait_data = 1'b0;
                end else val_wait--;
            end else if (rd_req && gnt_wait == 0) begin
                rd_gnt = 1'b1; pend_addr = rd_addr; wait_data = 1'b1; reads++;
                val_wait = rand_mode ? $urandom_range(0, 5) : 0;
                gnt_wait = rand_mode ? $urandom_range(0, 5) : 0;
            end else begin
                if (rd_req) gnt_wait--;
                if (rand_mode && $urandom_range(0, 3) == 0) begin
                    rd_valid = 1'b1; rd_data = 16'h7abc;
                end
            end
        end
    end

    // Write port: acknowledge after a random wait.
    initial begin
        wr_ack = 1'b0;
        forever begin
            @(negedge clk); #1;
            wr_ack = 1'b0;
            if (rst) ack_wait = 0;
            else if (wr_req) begin
                if (ack_wait == 0) begin
                    wr_ack = 1'b1;
                    ack_wait = rand_mode ? $urandom_range(0, 5) : 0;
                end else ack_wait--;
            end
        end
    end

    // Monitor: score accepted writes against the expected queue, log done pulses.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk); #3;
            if (rd_req) rdreq_cycles++;
            if (done) begin
                done_count++; done_cyc = cyc; done_err = err;
            end
            if (wr_req && wr_ack && !rst) begin
                writes++;
                check("write_expected", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("write_addr", wr_addr, e.addr);
                    check("write_data", 64'(wr_data), 64'(e.data));
                end
            end
        end
    end

    task automatic launch(input int m, input int h, input int w, input int k, input int s, output int t);
        @(negedge clk);
        mode = m[0]; cfg_src = SRC; cfg_dst = DST;
        cfg_h = DIM_W'(h); cfg_w = DIM_W'(w); cfg_k = 3'(k); cfg_s = 3'(s);
        start = 1'b1; t = cyc;
        @(negedge clk);
        start = 1'b0;
        mode = ~m[0]; cfg_src = {$urandom, $urandom}; cfg_dst = {$urandom, $urandom};
        cfg_h = DIM_W'($urandom); cfg_w = DIM_W'($urandom);
        cfg_k = 3'($urandom); cfg_s = 3'($urandom);
    endtask

    task automatic run_job(input int m, input int h, input int w, input int k, input int s,
                           input bit timing, input bit mid_start);
        int t, prev, r0, w0, q0, nrd, nout, budget;
        bit rej, found;
        rej = is_reject(m, h, w, k, s);
        prev = done_count; r0 = reads; w0 = writes; q0 = rdreq_cycles;
        nrd = 0; nout = 0;
        if (!rej) expect_job(m, h, w, k, s, nrd, nout);
        launch(m, h, w, k, s, t);
        if (mid_start) begin
            repeat (3) @(negedge clk);
            start = 1'b1; mode = ~m[0]; cfg_h = 16'd2; cfg_w = 16'd2; cfg_k = 3'd1; cfg_s = 3'd1;
            @(negedge clk);
            start = 1'b0;
        end
        found = 1'b0; budget = 20000;
        #4;
        while (!found && budget > 0) begin
            if (done_count > prev) found = 1'b1;
            else begin
                @(negedge clk); #4; budget--;
            end
        end
        check("done_seen", 64'(found), 64'd1);
        if (found) begin
            check("done_err", 64'(done_err), 64'(rej));
            if (timing) check("done_cycle", 64'(done_cyc), 64'(t + 1 + nout * (2 * k * k + 1)));
            check("busy_at_done", 64'(busy), 64'd1);
            @(negedge clk); #4;
            check("busy_after_done", 64'(busy), 64'd0);
            repeat (4) @(negedge clk);
            check("single_done", 64'(done_count - prev), 64'd1);
        end
        check("read_count", 64'(reads - r0), 64'(nrd));
        check("write_count", 64'(writes - w0), 64'(nout));
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        if (rej) check("no_rd_req", 64'(rdreq_cycles - q0), 64'd0);
    endtask

    initial begin
        int m, k, h, w, s, t, prev, r0, nrd, nout;
        bit hit;
        rst = 1'b1; start = 1'b0; mode = 1'b0; cfg_src = '0; cfg_dst = '0;
        cfg_h = '0; cfg_w = '0; cfg_k = '0; cfg_s = '0;
        for (int i = 0; i < 256; i++) mem[i] = 16'(i);
        repeat (3) @(negedge clk);
        #4;
        check("rst_rd_req", 64'(rd_req), 64'd0);
        check("rst_wr_req", 64'(wr_req), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_rd_addr", rd_addr, 64'd0);
        check("rst_wr_addr", wr_addr, 64'd0);
        check("rst_wr_data", 64'(wr_data), 64'd0);
        rst = 1'b0;

        run_job(0, 4, 4, 2, 2, 1'b1, 1'b0);
        run_job(1, 4, 4, 2, 2, 1'b1, 1'b0);
        mem[0] = -16'sd1; mem[1] = -16'sd2; mem[2] = -16'sd1; mem[3] = -16'sd1;
        run_job(1, 2, 2, 2, 1, 1'b1, 1'b0);
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        run_job(0, 4, 5, 3, 1, 1'b1, 1'b0);
        run_job(1, 4, 4, 3, 1, 1'b1, 1'b0);
        run_job(0, 4, 4, 2, 0, 1'b1, 1'b0);
        run_job(0, 6, 6, 5, 1, 1'b1, 1'b0);
        run_job(0, 2, 4, 3, 1, 1'b1, 1'b0);

        rand_mode = 1'b1;
        run_job(0, 4, 4, 2, 2, 1'b0, 1'b1);
        run_job(1, 6, 6, 2, 2, 1'b0, 1'b1);
        for (int j = 0; j < 6; j++) begin
            for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
            m = $urandom_range(0, 1);
            if (m == 1) begin
                k = $urandom_range(0, 2);
                k = 1 << k;
            end else k = $urandom_range(1, 4);
            h = $urandom_range(k, 6); w = $urandom_range(k, 6); s = $urandom_range(1, 3);
            run_job(m, h, w, k, s, 1'b0, 1'b0);
        end

        // Reset in the middle of a read burst, then a clean job.
        prev = done_count; r0 = reads;
        expect_job(0, 4, 4, 2, 1, nrd, nout);
        launch(0, 4, 4, 2, 1, t);
        hit = 1'b0;
        for (int i = 0; i < 2000 && !hit; i++) begin
            @(negedge clk); #4;
            if (rd_req && (reads - r0) >= 3) hit = 1'b1;
        end
        check("reached_mid_read", 64'(hit), 64'd1);
        rst = 1'b1;
        @(negedge clk); #4;
        check("rd_req_after_rst", 64'(rd_req), 64'd0);
        check("busy_after_rst", 64'(busy), 64'd0);
        rst = 1'b0;
        exp_q.delete();
        repeat (20) @(negedge clk);
        check("no_done_after_rst", 64'(done_count - prev), 64'd0);
        run_job(1, 5, 5, 2, 1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pool_engine.md
# pool_engine

Parametrised, multi-cycle 2-D pooling engine for the custom-instruction accelerator. It supports max or average pooling with a configurable window, stride and feature-map size, and replaces the fixed 24→6 combinational max-pool path. It sits beside the matrix unit behind the instruction decoder. It fetches int16 elements one at a time over a req/gnt/rvalid memory port and writes one pooled result per output element. The decoder holds `pc_stall` while `busy` is high.

## Interface
Parameters:
- `DATA_W`, 16: element width, signed two's complement.
- `ADDR_W`, 64: byte-address width.
- `DIM_W`, 16: width of the height/width configuration fields.
- `MAX_K`, 4: largest legal window edge.

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: reset, synchronous, active-high.
- `start`  in  1: launch pulse; sampled only in IDLE.
- `mode`  in  1: 0 = max, 1 = average.
- `cfg_src`, `cfg_dst`  in  ADDR_W: byte base addresses, 2-byte aligned.
- `cfg_h`, `cfg_w`  in  DIM_W: input height and width.
- `cfg_k`, `cfg_s`  in  3: window edge and stride.
- `rd_req`  out  1 / `rd_addr`  out  ADDR_W / `rd_gnt`  in  1: read address handshake.
- `rd_valid`  in  1 / `rd_data`  in  DATA_W: read data return.
- `wr_req`  out  1 / `wr_addr`  out  ADDR_W / `wr_data`  out  DATA_W / `wr_ack`  in  1: write handshake.
- `busy`  out  1: high whenever the FSM is not in IDLE.
- `done`  out  1: 1-cycle completion pulse.
- `err`  out  1: asserted together with `done` when the configuration is rejected.

## Operation
- Configuration inputs are latched on the accepted `start`. Changes afterwards are ignored until the next job.
- Output dimensions: OH = (H−K)/S+1 and OW = (W−K)/S+1, using unsigned floor division.
- Traversal order is output row-major; within each window, the order is also row-major.
- Read address: src + 2·((oy·S+ky)·W + ox·S+kx).
- Write address: dst + 2·(oy·OW+ox).
- Reject conditions: K=0, K>MAX_K, S=0, K>H, K>W, or mode=1 with K∉{1,2,4}.
  - On reject: no memory traffic; `done` and `err` pulse in the cycle after `start`.
- FSM: IDLE → RD_REQ → RD_WAIT → (window incomplete ? RD_REQ : WR_REQ) → (more outputs ? RD_REQ : DONE) → IDLE. A rejected start goes IDLE → DONE directly.
- Max mode: the accumulator loads the first element of the window, then takes the signed max of each subsequent element.
- Average mode:
  - Sum width is DATA_W + 2·clog2(MAX_K) bits, signed.
  - Result = sum >>> log2(K·K), an arithmetic shift that floors toward −∞.
  - The result is truncated to DATA_W; it always fits.
- Only one read is outstanding at a time. `rd_valid` is accepted only in RD_WAIT; `rd_valid` in any other state is ignored.
- `start` received while `busy` is ignored.
- A `rst` mid-job returns the FSM to IDLE in the next cycle. It drops `rd_req`/`wr_req`, and no `done` is produced.
- Reset values: `rd_req`, `wr_req`, `busy`, `done` and `err` are 0; `rd_addr`, `wr_addr` and `wr_data` are 0.

## Timing
- `start` accepted at cycle t → `busy` and `rd_req` are high at t+1.
- `rd_req` and `rd_addr` are held stable until the cycle in which `rd_gnt` is high. The FSM moves to RD_WAIT in the next cycle.
- `rd_valid` may arrive at the earliest one cycle after `rd_gnt`. The element is consumed in the `rd_valid` cycle.
- `wr_req`, `wr_addr` and `wr_data` are held until `wr_ack`. The address and data update only after the ack.
- Zero-wait memory (gnt in the same cycle as req, rvalid the next cycle, ack in the same cycle as wr_req):
  - Each output takes 2·K² + 1 cycles.
  - `done` is at t + 1 + OH·OW·(2K²+1).
  - `busy` falls in the cycle after `done`.

## Structure
- Package `pool_pkg`:
  - FSM state enum.
  - Mode enum (`POOL_MAX`, `POOL_AVG`).
  - The `pool_cfg_t` struct of latched configuration fields.
  - The `log2_k2` lookup function.
- Sub-module `pool_reduce`:
  - Holds the accumulator register and the max/sum datapath, with signals `clear`, `en` and `data`.
  - Produces a combinational `result` output with the shift/truncate applied.
- Top level owns the FSM, the ky/kx/oy/ox counters and address generation.

## Test plan
- 4×4 map of values 0..15, K=2, S=2, max → writes 5, 7, 13, 15 at dst+0, +2, +4, +6; `done` at t+37 with zero-wait memory.
- Same map in average mode → writes 2, 4, 10, 12.
- Window {−1, −2, −1, −1}, K=2, average → sum −5 → writes −2, confirming the floor.
- H=4, W=5, K=3, S=1, max → OH=2, OW=3; exactly 6 writes and 54 reads.
- K=3 in average mode, or S=0 → `err` and `done` at t+1, and `rd_req` never asserts.
- Random 0–5 cycle `rd_gnt`/`rd_valid`/`wr_ack` delays with a second `start` mid-job → results identical and the second start ignored. Then `rst` mid-read → `rd_req` low at the next cycle, no `done`, and a fresh job completes correctly.
